axis_dwidth_converter_8_to_48: RTL and testbench

//  Narrow-to-wide AXI-Stream packer: gathers 8-byte (64b) beats into 48-byte (384b) words.

---
 rtl/axis_dwidth_pkg.sv | 13 +
 rtl/axis_dwidth_converter_8_to_48.sv | 119 +++++++++++
 tb/tb_axis_dwidth_converter_8_to_48.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_dwidth_pkg.sv
// Shared widths and types for the 8<->48 byte AXI-Stream converter pair.
// Imported by both the 8-to-48 packer and the 48-to-8 downsizer.
package axis_dwidth_pkg;

    localparam int AXIS_NARROW_W = 64;
    localparam int AXIS_WIDE_W   = 384;
    localparam int AXIS_RATIO    = 6;
    localparam int AXIS_CNT_W    = $clog2(AXIS_RATIO);

    typedef logic [AXIS_WIDE_W-1:0]   wide_word_t;
    typedef logic [AXIS_WIDE_W/8-1:0] wide_keep_t;

endpackage

// File: rtl/axis_dwidth_converter_8_to_48.sv
// Narrow-to-wide AXI-Stream packer: six 8-byte beats into one 48-byte word.
// Partial words on tlast are zero-padded and marked through tkeep.
module axis_dwidth_converter_8_to_48
    import axis_dwidth_pkg::*;
#(
    parameter int IN_W  = AXIS_NARROW_W,
    parameter int RATIO = AXIS_RATIO
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [IN_W-1:0]           s_axis_tdata,
    input  logic                      s_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [IN_W*RATIO-1:0]     m_axis_tdata,
    output logic [IN_W*RATIO/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast
);

    localparam int OUT_W  = IN_W * RATIO;
    localparam int KEEP_W = OUT_W / 8;
    localparam int LANE_K = IN_W / 8;
    localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]  r_lane_cnt;
    logic [OUT_W-1:0]  r_acc;
    logic [KEEP_W-1:0] r_acc_keep;
    logic              r_acc_last;
    logic              r_acc_done;

    logic              r_m_valid;
    logic [OUT_W-1:0]  r_m_data;
    logic [KEEP_W-1:0] r_m_keep;
    logic              r_m_last;

    logic              w_out_free;
    logic              w_accept;
    logic              w_complete;
    logic              w_drain;
    logic              w_direct;
    logic              w_park;
    logic [OUT_W-1:0]  w_merge_data;
    logic [KEEP_W-1:0] w_merge_keep;

    // Ready is a pure register output: a parked word blocks new beats.
    assign s_axis_tready = !r_acc_done;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tlast  = r_m_last;

    assign w_out_free = !r_m_valid || m_axis_tready;
    assign w_accept   = s_axis_tvalid && !r_acc_done;
    assign w_complete = (r_lane_cnt == LAST_LANE) || s_axis_tlast;
    assign w_drain    = r_acc_done && w_out_free;
    assign w_direct   = w_accept && w_complete && w_out_free;
    assign w_park     = w_accept && w_complete && !w_out_free;

    // Accumulator with the incoming beat dropped into the current lane.
    always_comb begin
        w_merge_data = r_acc;
        w_merge_keep = r_acc_keep;
        w_merge_data[int'(r_lane_cnt)*IN_W +: IN_W]     = s_axis_tdata;
        w_merge_keep[int'(r_lane_cnt)*LANE_K +: LANE_K] = {LANE_K{1'b1}};
    end

    // Accumulator: gather lanes, park a finished word when output is busy.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_lane_cnt <= '0;
            r_acc      <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
            r_acc_done <= 1'b0;
        end else if (w_drain || w_direct) begin
            r_lane_cnt <= '0;
            r_acc      <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
            r_acc_done <= 1'b0;
        end else if (w_park) begin
            r_lane_cnt <= '0;
            r_acc      <= w_merge_data;
            r_acc_keep <= w_merge_keep;
            r_acc_last <= s_axis_tlast;
            r_acc_done <= 1'b1;
        end else if (w_accept) begin
            r_lane_cnt <= r_lane_cnt + CNT_W'(1);
            r_acc      <= w_merge_data;
            r_acc_keep <= w_merge_keep;
        end
    end

    // Output register: load a parked or fresh word, else drop after transfer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_drain) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_acc;
            r_m_keep  <= r_acc_keep;
            r_m_last  <= r_acc_last;
        end else if (w_direct) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_merge_data;
            r_m_keep  <= w_merge_keep;
            r_m_last  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_dwidth_converter_8_to_48.sv
// Directed bench for the 8-to-48 byte AXI-Stream packer.
// Output words are captured by a monitor and matched against a queue.
module tb_axis_dwidth_converter_8_to_48;

    typedef logic [432:0] wrd_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [63:0]  s_tdata = '0;
    logic         s_tlast = 1'b0;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [383:0] m_tdata;
    logic [47:0]  m_tkeep;
    logic         m_tlast;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rdy_low = 0;
    int got_rd  = 0;
    bit done    = 1'b0;

    wrd_t got_q[$];
    wrd_t exp_q[$];

    axis_dwidth_converter_8_to_48 dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Capture handshakes mid-cycle; inputs only change just after posedge.
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_tvalid && m_tready)
                got_q.push_back({m_tlast, m_tkeep, m_tdata});
            if (!s_tready)
                rdy_low++;
        end
    end

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        int t;
        t = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        forever begin
            @(negedge aclk);
            if (s_tready) break;
            t++;
            if (t > 1000) break;
        end
        if (t > 1000) chk("s_accept_tmo", t, 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic s_idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while ((got_q.size() - got_rd) < n && t < 200) begin
            @(posedge aclk);
            #1;
            t++;
        end
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, got_q.size() - got_rd, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (got_rd + i < got_q.size())
                chk(tag, got_q[got_rd + i], exp_q[i]);
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    function automatic logic [383:0] seq_word(input int base);
        logic [383:0] w;
        for (int l = 0; l < 6; l++)
            w[l*64 +: 64] = 64'(base + l);
        return w;
    endfunction

    initial begin
        logic [383:0] wd;
        logic [63:0]  d;
        int c0, r0, nw;

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_s_tready", s_tready, 1);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_tlast", m_tlast, 0);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // one full packet, latency of one cycle
        for (int k = 1; k <= 6; k++)
            send_beat(64'(k), k == 6);
        chk("t1_valid", m_tvalid, 1);
        chk("t1_data", m_tdata,
            {64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1});
        chk("t1_keep", m_tkeep, 48'hFFFF_FFFF_FFFF);
        chk("t1_last", m_tlast, 1);
        exp_q.push_back({1'b1, 48'hFFFF_FFFF_FFFF,
            {64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1}});
        s_idle();
        chk("t1_drop", m_tvalid, 0);
        check_words("t1");

        // partial 3-beat word then a full word
        for (int k = 1; k <= 3; k++)
            send_beat(64'(16'hAA00 + k), k == 3);
        for (int k = 1; k <= 6; k++)
            send_beat(64'(16'hBB00 + k), k == 6);
        s_idle();
        exp_q.push_back({1'b1, 48'h0000_00FF_FFFF,
            {192'd0, 64'hAA03, 64'hAA02, 64'hAA01}});
        exp_q.push_back({1'b1, 48'hFFFF_FFFF_FFFF,
            {64'hBB06, 64'hBB05, 64'hBB04,
             64'hBB03, 64'hBB02, 64'hBB01}});
        wait_out(2);
        check_words("t2");

        // 24 back-to-back beats, no input bubbles
        r0 = rdy_low;
        c0 = cyc;
        for (int k = 0; k < 24; k++)
            send_beat(64'(16'hC000 + k), k == 23);
        chk("t3_cycles", cyc - c0, 24);
        s_idle();
        for (int w = 0; w < 4; w++)
            exp_q.push_back({w == 3, 48'hFFFF_FFFF_FFFF,
                seq_word(16'hC000 + 6 * w)});
        wait_out(4);
        chk("t3_rdy_low", rdy_low - r0, 0);
        check_words("t3");

        // downstream stall: parked word blocks input, drains in order
        m_tready = 1'b0;
        fork
            begin
                for (int k = 0; k < 12; k++)
                    send_beat(64'(16'hD000 + k), k == 11);
                send_beat(64'hE001, 1'b1);
                s_idle();
            end
            begin
                repeat (18) begin
                    @(posedge aclk);
                    #1;
                end
                chk("t4_stall_rdy", s_tready, 0);
                chk("t4_hold_valid", m_tvalid, 1);
                chk("t4_hold_data", m_tdata, seq_word(16'hD000));
                m_tready = 1'b1;
            end
        join
        exp_q.push_back({1'b0, 48'hFFFF_FFFF_FFFF, seq_word(16'hD000)});
        exp_q.push_back({1'b1, 48'hFFFF_FFFF_FFFF, seq_word(16'hD006)});
        exp_q.push_back({1'b1, 48'h0000_0000_00FF, {320'd0, 64'hE001}});
        wait_out(3);
        check_words("t4");

        // async reset mid-packet discards the partial word
        for (int k = 1; k <= 3; k++)
            send_beat(64'(16'hF000 + k), 1'b0);
        s_idle();
        #3 areset = 1'b1;
        #1;
        chk("t5_s_tready", s_tready, 1);
        chk("t5_m_tvalid", m_tvalid, 0);
        chk("t5_m_tdata", m_tdata, 0);
        chk("t5_m_tkeep", m_tkeep, 0);
        chk("t5_m_tlast", m_tlast, 0);
        #2 areset = 1'b0;
        @(posedge aclk);
        #1;
        for (int k = 0; k < 6; k++)
            send_beat(64'(16'h5A00 + k), k == 5);
        s_idle();
        exp_q.push_back({1'b1, 48'hFFFF_FFFF_FFFF, seq_word(16'h5A00)});
        wait_out(1);
        repeat (5) s_idle();
        check_words("t5");

        // random valid/ready, 200 packets of whole words
        fork
            begin
                for (int p = 0; p < 200; p++) begin
                    nw = $urandom_range(1, 3);
                    for (int w = 0; w < nw; w++) begin
                        for (int l = 0; l < 6; l++) begin
                            d = {$urandom, $urandom};
                            wd[l*64 +: 64] = d;
                            if ($urandom_range(0, 3) == 0) s_idle();
                            send_beat(d, (w == nw - 1) && (l == 5));
                        end
                        exp_q.push_back({w == nw - 1,
                            48'hFFFF_FFFF_FFFF, wd});
                    end
                end
                s_idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_tready = 1'($urandom_range(0, 1));
                    @(posedge aclk);
                    #1;
                end
            end
        join
        m_tready = 1'b1;
        wait_out(exp_q.size());
        check_words("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
